// File: rtl/if_stage.sv
// MIPS fetch stage: PC register, next-PC select, instruction ROM addressing and IF/ID register.
// Optional macro IF_BOUND_CHECK_EN adds a sticky fetch_err flag for misaligned/out-of-ROM PCs.
module if_stage #(
   parameter logic [31:0] PC_RESET = 32'h0000_3000,
   parameter int          IM_AW    = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             redirect,
   input  logic [31:0]      redirect_pc,
   output logic [IM_AW-1:0] im_addr,
   input  logic [31:0]      im_instr,
   output logic [31:0]      if_pc,
   output logic [31:0]      id_instr,
   output logic [31:0]      id_pc,
   output logic [31:0]      id_pc8,
   output logic [31:0]      fetch_cnt
`ifdef IF_BOUND_CHECK_EN
   ,
   output logic             fetch_err
`endif
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] id_instr_q, id_instr_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_pc8_q, id_pc8_d;
   logic [31:0] cnt_q, cnt_d;
   logic        fetch_bad;

`ifdef IF_BOUND_CHECK_EN
   logic        err_q, err_d;
   // 33-bit limit so PC_RESET near the top of the address space cannot wrap
   logic [32:0] pc_lim;
   assign pc_lim    = {1'b0, PC_RESET} + (33'd1 << (IM_AW + 2));
   assign fetch_bad = (pc_q[1:0] != 2'b00) || (pc_q < PC_RESET) ||
                      ({1'b0, pc_q} >= pc_lim);
   assign fetch_err = err_q;
`else
   assign fetch_bad = 1'b0;
`endif

   assign im_addr   = IM_AW'((pc_q - PC_RESET) >> 2);
   assign if_pc     = pc_q;
   assign id_instr  = id_instr_q;
   assign id_pc     = id_pc_q;
   assign id_pc8    = id_pc8_q;
   assign fetch_cnt = cnt_q;

   always_comb begin
      pc_d       = pc_q;
      id_instr_d = id_instr_q;
      id_pc_d    = id_pc_q;
      id_pc8_d   = id_pc8_q;
      cnt_d      = cnt_q;
`ifdef IF_BOUND_CHECK_EN
      err_d      = err_q;
`endif
      // Stall freezes everything, including a pending redirect; ID re-presents it later
      if (!stall) begin
         pc_d       = redirect ? redirect_pc : pc_q + 32'd4;
         id_instr_d = fetch_bad ? 32'h0 : im_instr;
         id_pc_d    = pc_q;
         id_pc8_d   = pc_q + 32'd8;
         cnt_d      = cnt_q + 32'd1;
`ifdef IF_BOUND_CHECK_EN
         err_d      = err_q | fetch_bad;
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q       <= PC_RESET;
         id_instr_q <= 32'h0;
         id_pc_q    <= 32'h0;
         id_pc8_q   <= 32'h0;
         cnt_q      <= 32'h0;
`ifdef IF_BOUND_CHECK_EN
         err_q      <= 1'b0;
`endif
      end else begin
         pc_q       <= pc_d;
         id_instr_q <= id_instr_d;
         id_pc_q    <= id_pc_d;
         id_pc8_q   <= id_pc8_d;
         cnt_q      <= cnt_d;
`ifdef IF_BOUND_CHECK_EN
         err_q      <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: random stall/redirect stimulus against a PC-level reference model.
module tb_if_stage;
   localparam logic [31:0] PC_RESET = 32'h0000_3000;
   localparam int          IM_AW    = 10;

   logic             clk = 1'b0;
   logic             reset;
   logic             stall;
   logic             redirect;
   logic [31:0]      redirect_pc;
   logic [IM_AW-1:0] im_addr;
   logic [31:0]      im_instr;
   logic [31:0]      if_pc, id_instr, id_pc, id_pc8, fetch_cnt;
`ifdef IF_BOUND_CHECK_EN
   logic             fetch_err;
`endif

   logic [31:0] rom [1024];
   assign im_instr = rom[im_addr];

   if_stage #(.PC_RESET(PC_RESET), .IM_AW(IM_AW)) dut (
      .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .im_addr(im_addr), .im_instr(im_instr),
      .if_pc(if_pc), .id_instr(id_instr), .id_pc(id_pc), .id_pc8(id_pc8),
      .fetch_cnt(fetch_cnt)
`ifdef IF_BOUND_CHECK_EN
      , .fetch_err(fetch_err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc, instr, ipc, ipc8, cnt, addr;
      logic        err;
   } exp_t;
   exp_t q[$];

   int checks = 0;
   int errors = 0;

   // Reference model state, in architectural terms
   logic [31:0] m_pc, m_instr, m_ipc, m_ipc8, m_cnt;
   logic        m_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] word_of(input logic [31:0] pc);
      return ((pc - PC_RESET) >> 2) % 1024;
   endfunction

   task automatic model_reset();
      m_pc = PC_RESET; m_instr = 0; m_ipc = 0; m_ipc8 = 0; m_cnt = 0; m_err = 0;
   endtask

   task automatic step(input logic s, input logic r, input logic [31:0] rpc);
      exp_t e;
      logic bad;
      @(negedge clk);
      stall = s; redirect = r; redirect_pc = rpc;
      if (!s) begin
         bad = 1'b0;
`ifdef IF_BOUND_CHECK_EN
         bad = (m_pc % 4 != 0) || (m_pc < PC_RESET) ||
               (64'(m_pc) >= 64'(PC_RESET) + 64'(4 * 1024));
`endif
         m_instr = bad ? 32'h0 : rom[word_of(m_pc)];
         m_err   = m_err | bad;
         m_ipc   = m_pc;
         m_ipc8  = m_pc + 8;
         m_cnt   = m_cnt + 1;
         m_pc    = r ? rpc : m_pc + 4;
      end
      e.pc = m_pc; e.instr = m_instr; e.ipc = m_ipc; e.ipc8 = m_ipc8;
      e.cnt = m_cnt; e.addr = word_of(m_pc); e.err = m_err;
      q.push_back(e);
   endtask

   // Monitor: compares every cycle the DUT has an expected response for
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (!reset && q.size() > 0) begin
         e = q.pop_front();
         chk("if_pc", if_pc, e.pc);
         chk("im_addr", 32'(im_addr), e.addr);
         chk("id_instr", id_instr, e.instr);
         chk("id_pc", id_pc, e.ipc);
         chk("id_pc8", id_pc8, e.ipc8);
         chk("fetch_cnt", fetch_cnt, e.cnt);
`ifdef IF_BOUND_CHECK_EN
         chk("fetch_err", 32'(fetch_err), 32'(e.err));
`endif
      end
   end

   task automatic drain();
      int budget = 10;
      while (q.size() > 0 && budget > 0) begin
         @(posedge clk); budget--;
      end
      @(posedge clk); #3;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
      end
   endtask

   initial begin
      logic [31:0] t;
      for (int i = 0; i < 1024; i++) rom[i] = $urandom;
      rom[0] = 32'h3c01_1234;
      reset = 1'b1; stall = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_if_pc", if_pc, PC_RESET);
      chk("rst_id_instr", id_instr, 32'h0);
      chk("rst_id_pc", id_pc, 32'h0);
      chk("rst_id_pc8", id_pc8, 32'h0);
      chk("rst_cnt", fetch_cnt, 32'h0);
      @(negedge clk); reset = 1'b0;

      // Sequential fetch, redirect with delay slot, stalls
      repeat (3) step(0, 0, 0);
      step(0, 1, 32'h3040);
      step(0, 0, 0);
      step(1, 0, 0); step(1, 0, 0);
      step(0, 0, 0);
      // Stall beats redirect; redirect re-presented in next free cycle
      step(1, 1, 32'h3100);
      step(0, 1, 32'h3100);
      step(0, 0, 0);
      // Misaligned target, below-ROM target, wrap of 32-bit PC
      step(0, 1, 32'h3101); step(0, 0, 0);
      step(0, 1, 32'h2ffc); step(0, 0, 0);
      step(0, 1, PC_RESET);  step(0, 0, 0);
      step(0, 1, 32'hffff_fff8); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
      step(0, 1, PC_RESET + 32'd4092); step(0, 0, 0);

      for (int i = 0; i < 400; i++) begin
         t = ($urandom_range(0, 7) == 0) ? $urandom
                                         : PC_RESET + 4 * $urandom_range(0, 1023);
         step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, t);
      end
      step(1, 0, 0);
      drain();

      // Asynchronous reset between edges while mid-redirect
      step(0, 1, 32'h3044); step(0, 0, 0); step(1, 1, 32'h3200);
      drain();
      reset = 1'b1;
      #1;
      chk("arst_if_pc", if_pc, PC_RESET);
      chk("arst_id_instr", id_instr, 32'h0);
      chk("arst_cnt", fetch_cnt, 32'h0);
      chk("arst_id_pc", id_pc, 32'h0);
      model_reset();
      @(negedge clk); reset = 1'b0;
      repeat (4) step(0, 0, 0);
      step(1, 0, 0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, limit 200000");
      $fatal(1);
   end
endmodule
